// File: rtl/ti_roic_tx_emulator.sv
// TI ROIC LVDS lane emulator: MSB-first word serializer with frame clock, training patterns and line framing.
// Optional internal ramp source is compiled in when `TI_ROIC_TX_TEST_PATTERN_EN is defined.
module ti_roic_tx_emulator #(
  parameter int                    DATA_WIDTH    = 24,
  parameter logic [DATA_WIDTH-1:0] PATTERN_1     = DATA_WIDTH'(24'hFFF000),
  parameter logic [DATA_WIDTH-1:0] PATTERN_2     = DATA_WIDTH'(24'hFF0000),
  parameter logic [DATA_WIDTH-1:0] FIRST_CH_MARK = DATA_WIDTH'(24'hA5A5A5),
  parameter int                    NUM_CH        = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  train_en,
  input  logic                  line_start,
  input  logic [DATA_WIDTH-1:0] word_in,
  input  logic                  word_valid,
  output logic                  word_ready,
  input  logic                  tp_en,
  output logic                  ser_out,
  output logic                  fclk_out,
  output logic                  word_strobe,
  output logic                  busy,
  output logic                  line_done,
  output logic                  underflow
);

  localparam int BW = $clog2(DATA_WIDTH);
  localparam int CW = $clog2(NUM_CH + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);
  localparam logic [BW-1:0] HALF_BIT = BW'(DATA_WIDTH / 2);
  localparam logic [CW-1:0] LAST_CH  = CW'(NUM_CH);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_DATA = 1'b1;

  logic [0:0]            state, state_d;
  logic [BW-1:0]         bit_cnt, bit_nxt;
  logic [CW-1:0]         ch_cnt, ch_cnt_d;
  logic [DATA_WIDTH-1:0] shreg, shreg_d, word_sel;
  logic                  pending, pending_d;
  logic                  train_ph, train_ph_d;
  logic                  underflow_d;
  logic                  boundary, in_line, line_end, ramp_active;

`ifdef TI_ROIC_TX_TEST_PATTERN_EN
  logic        tp_line, tp_line_d;
  logic [11:0] line_cnt, line_cnt_d;
  logic [11:0] ch_lo;
  logic [23:0] ramp_word;

  assign ch_lo       = 12'(ch_cnt);
  assign ramp_word   = {line_cnt, ch_lo};
  assign ramp_active = tp_line;
`else
  logic unused_tp;

  assign unused_tp   = tp_en;
  assign ramp_active = 1'b0;
`endif

  // A word boundary is the edge that ends the last bit of the current word.
  assign boundary = (bit_cnt == LAST_BIT);
  assign bit_nxt  = boundary ? '0 : bit_cnt + BW'(1);
  assign in_line  = (state == ST_DATA) && (ch_cnt != LAST_CH);
  assign line_end = (state == ST_DATA) && (ch_cnt == LAST_CH);

  always_comb begin
    // NOTE: every variable gets a default up front so no path leaves one unassigned and infers a latch.
    state_d     = state;
    ch_cnt_d    = ch_cnt;
    word_sel    = '0;
    pending_d   = pending | ((state == ST_IDLE) & line_start);
    train_ph_d  = train_en & train_ph;
    underflow_d = underflow;
    shreg_d     = shreg << 1;
`ifdef TI_ROIC_TX_TEST_PATTERN_EN
    tp_line_d   = tp_line;
    line_cnt_d  = line_cnt;
`endif
    if (boundary) begin
      if (in_line) begin
        ch_cnt_d = ch_cnt + CW'(1);
`ifdef TI_ROIC_TX_TEST_PATTERN_EN
        if (tp_line)         word_sel = DATA_WIDTH'(ramp_word);
        else if (word_valid) word_sel = word_in;
        else                 underflow_d = 1'b1;
`else
        if (word_valid) word_sel = word_in;
        else            underflow_d = 1'b1;
`endif
      end else begin
`ifdef TI_ROIC_TX_TEST_PATTERN_EN
        if (line_end) line_cnt_d = line_cnt + 12'd1;
`endif
        // Idle rules also apply right after the last channel word of a line.
        if (pending_d) begin
          state_d    = ST_DATA;
          ch_cnt_d   = '0;
          word_sel   = FIRST_CH_MARK;
          pending_d  = 1'b0;
          train_ph_d = 1'b0;
`ifdef TI_ROIC_TX_TEST_PATTERN_EN
          tp_line_d  = tp_en;
`endif
        end else begin
          state_d = ST_IDLE;
          if (train_en) begin
            word_sel   = train_ph ? PATTERN_2 : PATTERN_1;
            train_ph_d = ~train_ph;
          end
        end
      end
      shreg_d = word_sel << 1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      bit_cnt     <= LAST_BIT;
      ch_cnt      <= '0;
      shreg       <= '0;
      pending     <= 1'b0;
      train_ph    <= 1'b0;
      underflow   <= 1'b0;
      ser_out     <= 1'b0;
      fclk_out    <= 1'b0;
      word_strobe <= 1'b0;
      busy        <= 1'b0;
      word_ready  <= 1'b0;
      line_done   <= 1'b0;
    end else begin
      state       <= state_d;
      bit_cnt     <= bit_nxt;
      ch_cnt      <= ch_cnt_d;
      shreg       <= shreg_d;
      pending     <= pending_d;
      train_ph    <= train_ph_d;
      underflow   <= underflow_d;
      ser_out     <= boundary ? word_sel[DATA_WIDTH-1] : shreg[DATA_WIDTH-1];
      fclk_out    <= (bit_nxt < HALF_BIT);
      word_strobe <= boundary;
      busy        <= (state_d == ST_DATA);
      // Ready/done are raised for the last bit of the word preceding the slot / ending the line.
      word_ready  <= (bit_nxt == LAST_BIT) && in_line && !ramp_active;
      line_done   <= (bit_nxt == LAST_BIT) && line_end;
    end
  end

`ifdef TI_ROIC_TX_TEST_PATTERN_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      tp_line  <= 1'b0;
      line_cnt <= '0;
    end else begin
      tp_line  <= tp_line_d;
      line_cnt <= line_cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_ti_roic_tx_emulator.sv
// Self-checking bench for ti_roic_tx_emulator: per-cycle comparison against a word-level model plus literal stream checks.
module tb_ti_roic_tx_emulator;

  localparam int W = 24;
  localparam int N = 4;
  localparam logic [W-1:0] P1   = 24'hFFF000;
  localparam logic [W-1:0] P2   = 24'hFF0000;
  localparam logic [W-1:0] MARK = 24'hA5A5A5;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         train_en = 1'b0, line_start = 1'b0, word_valid = 1'b0, tp_en = 1'b0;
  logic [W-1:0] word_in = '0;
  logic         word_ready, ser_out, fclk_out, word_strobe, busy, line_done, underflow;

  always #5 clk = ~clk;

  ti_roic_tx_emulator #(.NUM_CH(N)) dut (
    .clk(clk), .rst(rst), .train_en(train_en), .line_start(line_start),
    .word_in(word_in), .word_valid(word_valid), .word_ready(word_ready), .tp_en(tp_en),
    .ser_out(ser_out), .fclk_out(fclk_out), .word_strobe(word_strobe), .busy(busy),
    .line_done(line_done), .underflow(underflow)
  );

  // ---------------- word-level reference model ----------------
  int           m_i = W - 1, m_kind = 0, m_k = 0, m_lines = 0;  // kind: 0 idle, 1 marker, 2 channel
  logic [W-1:0] m_word = '0;
  bit           m_pend = 0, m_ph = 0, m_uf = 0, m_tp = 0, m_zero = 1, m_known = 0;

  always @(posedge clk) begin
    m_known = 1'b1;
    if (rst) begin
      m_zero = 1'b1; m_i = W - 1; m_kind = 0; m_k = 0; m_lines = 0;
      m_pend = 0; m_ph = 0; m_uf = 0; m_tp = 0; m_word = '0;
    end else begin
      m_zero = 1'b0;
      if (m_kind == 0 && !m_pend && line_start) m_pend = 1'b1;
      if (m_i == W - 1) begin
        m_i = 0;
        if (m_kind != 0 && m_k < N) begin
          m_kind = 2;
          m_k    = m_k + 1;
          if (m_tp)            m_word = W'({m_lines[11:0], 12'(m_k - 1)});
          else if (word_valid) m_word = word_in;
          else begin m_word = '0; m_uf = 1'b1; end
        end else begin
          if (m_kind == 2) m_lines = m_lines + 1;
          if (m_pend) begin
            m_kind = 1; m_k = 0; m_pend = 0; m_ph = 0; m_word = MARK;
`ifdef TI_ROIC_TX_TEST_PATTERN_EN
            m_tp = tp_en;
`endif
          end else begin
            m_kind = 0;
            if (train_en) begin m_word = m_ph ? P2 : P1; m_ph = !m_ph; end
            else m_word = '0;
          end
        end
      end else begin
        m_i = m_i + 1;
      end
      if (!train_en) m_ph = 1'b0;
    end
  end

  function automatic logic [6:0] model_out();
    if (m_zero) return '0;
    return {m_word[W-1-m_i], 1'(m_i < W / 2), 1'(m_i == 0), 1'(m_kind != 0),
            1'(m_i == W - 1 && m_kind != 0 && m_k < N && !m_tp),
            1'(m_i == W - 1 && m_kind == 2 && m_k == N), m_uf};
  endfunction

  function automatic logic [6:0] outs();
    return {ser_out, fclk_out, word_strobe, busy, word_ready, line_done, underflow};
  endfunction

  // ---------------- checking helpers ----------------
  int n_checks = 0, n_errors = 0, cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  logic [W-1:0] dq[$];
  logic [W-1:0] dec = '0;
  int           dcnt = 0;
  logic [W:0]   feed[$];   // {valid, data} offered at each ready cycle
  int           n_strobe = 0, n_fclk = 0, n_ones = 0, n_ready = 0, n_done = 0, n_busy = 0;

  task automatic zero_counts();
    n_strobe = 0; n_fclk = 0; n_ones = 0; n_ready = 0; n_done = 0; n_busy = 0;
  endtask

  task automatic tick(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      cyc++;
      if (m_known) check("outputs", 32'(outs()), 32'(model_out()));
      if (word_strobe) begin dec = {{(W-1){1'b0}}, ser_out}; dcnt = 1; end
      else if (dcnt > 0) begin dec = {dec[W-2:0], ser_out}; dcnt++; end
      if (dcnt == W) begin dq.push_back(dec); dcnt = 0; end
      n_strobe += int'(word_strobe); n_fclk += int'(fclk_out); n_ones += int'(ser_out);
      n_ready  += int'(word_ready);  n_done += int'(line_done); n_busy += int'(busy);
      if (word_ready && feed.size() > 0) begin
        {word_valid, word_in} = feed.pop_front();
      end else if (word_ready) begin
        word_valid = ($urandom_range(0, 9) != 0);
        word_in    = W'($urandom);
      end else begin
        word_valid = 1'($urandom_range(0, 1));
        word_in    = W'($urandom);
      end
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1; line_start = 1'b0;
    tick(n);
    rst = 1'b0;
    feed.delete(); dq.delete(); dcnt = 0;
  endtask

  task automatic pulse_line();
    line_start = 1'b1;
    tick(1);
    line_start = 1'b0;
  endtask

  function automatic logic [W-1:0] dq_at(input int i);
    return (i < dq.size()) ? dq[i] : 24'h0BAD00;
  endfunction

  task automatic check_line(input string name, input logic [W-1:0] e0, e1, e2, e3, inout int from);
    int           idx = -1;
    logic [W-1:0] e[4];
    e = '{e0, e1, e2, e3};
    for (int j = from; j < dq.size(); j++) if (idx < 0 && dq[j] == MARK) idx = j;
    check({name, "_found"}, 32'(idx >= 0 && idx + 4 < dq.size()), 32'd1);
    if (idx >= 0 && idx + 4 < dq.size()) begin
      for (int s = 0; s < 4; s++) check($sformatf("%s_word%0d", name, s), 32'(dq[idx+1+s]), 32'(e[s]));
      from = idx + 5;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int           pos;
    int           marks;
    logic [W-1:0] r[4];

    // Reset, then idle with training off.
    tick(3);
    check("reset_outputs", 32'(outs()), 32'd0);
    rst = 1'b0; dq.delete(); dcnt = 0;
    zero_counts();
    tick(72);
    check("idle_strobes", n_strobe, 3);
    check("idle_fclk_high", n_fclk, 36);
    check("idle_ser_ones", n_ones, 0);
    check("idle_busy", n_busy, 0);

    // Training alternation, drop and re-raise.
    train_en = 1'b1;
    do_reset(2);
    tick(96);
    check("train_count", dq.size(), 4);
    check("train_w0", 32'(dq_at(0)), 32'(P1));
    check("train_w1", 32'(dq_at(1)), 32'(P2));
    check("train_w2", 32'(dq_at(2)), 32'(P1));
    check("train_w3", 32'(dq_at(3)), 32'(P2));
    train_en = 1'b0; dq.delete();
    tick(48);
    train_en = 1'b1;
    tick(48);
    check("retrain_w0", 32'(dq_at(0)), 32'h0);
    check("retrain_w2", 32'(dq_at(2)), 32'(P1));
    check("retrain_w3", 32'(dq_at(3)), 32'(P2));

    // Plain line of four channel words.
    train_en = 1'b0;
    do_reset(2);
    feed = '{{1'b1, 24'h000011}, {1'b1, 24'h000022}, {1'b1, 24'h000033}, {1'b1, 24'h000044}};
    zero_counts();
    pulse_line();
    tick(24 * 7);
    pos = 0;
    check_line("line1", 24'h11, 24'h22, 24'h33, 24'h44, pos);
    check("line1_ready", n_ready, 4);
    check("line1_done", n_done, 1);
    check("line1_busy", n_busy, 120);
    check("line1_uflow", 32'(underflow), 32'd0);
    check("line1_feed_used", feed.size(), 0);

    // Underflow on the third slot, then a normal line.
    feed = '{{1'b1, 24'h000011}, {1'b1, 24'h000022}, {1'b0, 24'h000033}, {1'b1, 24'h000044}};
    dq.delete(); zero_counts();
    pulse_line();
    tick(24 * 7);
    pos = 0;
    check_line("uf", 24'h11, 24'h22, 24'h0, 24'h44, pos);
    check("uf_flag", 32'(underflow), 32'd1);
    check("uf_busy", n_busy, 120);
    for (int s = 0; s < 4; s++) begin
      r[s] = W'($urandom);
      feed.push_back({1'b1, r[s]});
    end
    dq.delete(); zero_counts();
    pulse_line();
    tick(24 * 7);
    pos = 0;
    check_line("after_uf", r[0], r[1], r[2], r[3], pos);
    check("uf_sticky", 32'(underflow), 32'd1);
    check("after_uf_done", n_done, 1);

    // Second request while busy is ignored.
    do_reset(2);
    feed = '{{1'b1, 24'h0000A1}, {1'b1, 24'h0000A2}, {1'b1, 24'h0000A3}, {1'b1, 24'h0000A4}};
    zero_counts();
    pulse_line();
    tick(50);
    pulse_line();
    tick(24 * 8);
    marks = 0;
    foreach (dq[j]) if (dq[j] == MARK) marks++;
    check("busy_req_markers", marks, 1);
    check("busy_req_done", n_done, 1);
    check("busy_req_busy", n_busy, 120);

    // Reset in the middle of word 2.
    feed = '{{1'b1, 24'h0000B1}, {1'b1, 24'h0000B2}, {1'b1, 24'h0000B3}, {1'b1, 24'h0000B4}};
    pulse_line();
    for (int t = 0; t < 60 && !busy; t++) tick(1);
    check("busy_seen", 32'(busy), 32'd1);
    tick(60);
    rst = 1'b1;
    tick(2);
    check("midline_reset_outputs", 32'(outs()), 32'd0);
    rst = 1'b0; feed.delete(); dq.delete(); dcnt = 0;
    zero_counts();
    tick(48);
    check("post_reset_busy", n_busy, 0);
    check("post_reset_strobes", n_strobe, 2);
    check("post_reset_fclk", n_fclk, 24);
    check("post_reset_ones", n_ones, 0);

`ifdef TI_ROIC_TX_TEST_PATTERN_EN
    // Ramp source: two lines, no handshake.
    tp_en = 1'b1;
    do_reset(2);
    zero_counts();
    pulse_line();
    tick(24 * 6);
    pulse_line();
    tick(24 * 7);
    pos = 0;
    check_line("ramp0", 24'h000000, 24'h000001, 24'h000002, 24'h000003, pos);
    check_line("ramp1", 24'h001000, 24'h001001, 24'h001002, 24'h001003, pos);
    check("ramp_ready", n_ready, 0);
    check("ramp_uflow", 32'(underflow), 32'd0);
    tp_en = 1'b0;
`endif

    // Randomized traffic checked cycle by cycle against the model.
    do_reset(2);
    for (int it = 0; it < 12; it++) begin
      train_en = 1'($urandom_range(0, 1));
      tp_en    = 1'($urandom_range(0, 1));
      tick($urandom_range(0, 40));
      pulse_line();
      tick($urandom_range(100, 220));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
